// File: rtl/unsaved_gpio_pkg.sv
// Shared constants for the unsaved_gpio input PIO: Avalon word addresses and edge-select codes.
package unsaved_gpio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Width of a counter that must reach max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/unsaved_gpio_sync.sv
// Per-bit multi-flop synchronizer for the external inputs, plus a one-cycle delayed copy
// of the synchronized value for edge detection.
module unsaved_gpio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] s_last,
    output logic [WIDTH-1:0] d_prev
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] d_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            d_prev_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            d_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_last = sync_q[SYNC_STAGES-1];
    assign d_prev = d_prev_q;

endmodule

// File: rtl/unsaved_gpio_in.sv
// Avalon-MM input PIO: synchronized pin readback, sticky per-bit edge capture with
// write-1-to-clear, and a maskable level interrupt.
module unsaved_gpio_in
    import unsaved_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int              PRIME_LAST = SYNC_STAGES + 1;
    localparam int              CW         = cnt_width(PRIME_LAST);
    localparam logic [CW-1:0]   PRIME_MAX  = CW'(PRIME_LAST);

    logic [WIDTH-1:0] s_last;
    logic [WIDTH-1:0] d_prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;

    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [CW-1:0]    prime_q, prime_d;
    logic             prime_done;
    logic             wr;
    logic             unused_wdata;

    unsaved_gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .s_last  (s_last),
        .d_prev  (d_prev)
    );

    assign wr           = chipselect & ~write_n;
    assign unused_wdata = &{1'b0, writedata};

    assign rise = s_last & ~d_prev;
    assign fall = ~s_last & d_prev;

    always_comb begin
        edge_hit = rise;
        case (EDGE_TYPE)
            EDGE_FALL: edge_hit = fall;
            EDGE_ANY:  edge_hit = rise | fall;
            default:   edge_hit = rise;
        endcase
    end

    // The sync chain and d_prev hold reset zeros until they have filled with real pin
    // values; suppress capture until then so a pin high at reset is not seen as a rise.
    assign prime_done = (prime_q == PRIME_MAX);

    always_comb begin
        prime_d   = prime_done ? prime_q : prime_q + 1'b1;
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr && address == ADDR_IRQMASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr && address == ADDR_EDGECAP) begin
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        end
        // Set is applied after clear so a same-cycle edge survives the clearing write.
        if (prime_done) begin
            edgecap_d = edgecap_d | edge_hit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask_q <= '0;
            edgecap_q <= '0;
            prime_q   <= '0;
        end else begin
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
            prime_q   <= prime_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = s_last;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_unsaved_gpio_in.sv
// Self-checking bench for unsaved_gpio_in: a rising-edge instance and an any-edge instance
// share the bus; each scenario task queues expectations and compares them as reads return.
module tb_unsaved_gpio_in;
    import unsaved_gpio_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [7:0]  in_port2;
    logic [31:0] readdata;
    logic [31:0] readdata2;
    logic        irq;
    logic        irq2;

    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic [31:0] got;
    logic [31:0] got2;
    int          checks;
    int          errors;

    unsaved_gpio_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISE)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    unsaved_gpio_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_ANY)) dut_any (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port2),
        .readdata   (readdata2),
        .irq        (irq2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: everything is driven and sampled 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d1, output logic [31:0] d2);
        address = a;
        #1;
        d1 = readdata;
        d2 = readdata2;
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        in_port  = 8'hFF;
        in_port2 = 8'h00;
        tick(3);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        bus_read(ADDR_DATA, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_data got %h exp %h", got, exp); end
        bus_read(ADDR_EDGECAP, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_edgecap got %h exp %h", got, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'b0, irq} !== exp) begin errors++; $display("FAIL reset_irq got %b exp %h", irq, exp); end

        reset = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hFF);
        tick(1);
        bus_read(ADDR_DATA, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL sync_1clk got %h exp %h", got, exp); end
        tick(1);
        bus_read(ADDR_DATA, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL sync_2clk got %h exp %h", got, exp); end

        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        tick(4);
        bus_read(ADDR_EDGECAP, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL prime_suppress got %h exp %h", got, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'b0, irq} !== exp) begin errors++; $display("FAIL prime_irq got %b exp %h", irq, exp); end
    endtask

    task automatic test_rise_capture;
        in_port = 8'h00;
        tick(4);
        bus_write(ADDR_IRQMASK, 32'h1);
        in_port = 8'h01;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h1);
        tick(1);
        bus_read(ADDR_EDGECAP, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rise_edge1 got %h exp %h", got, exp); end
        tick(1);
        bus_read(ADDR_EDGECAP, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rise_edge2 got %h exp %h", got, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'b0, irq} !== exp) begin errors++; $display("FAIL rise_irq_early got %b exp %h", irq, exp); end
        tick(1);
        bus_read(ADDR_EDGECAP, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rise_edge3 got %h exp %h", got, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'b0, irq} !== exp) begin errors++; $display("FAIL rise_irq got %b exp %h", irq, exp); end
    endtask

    task automatic test_w1c;
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h1);
        bus_write(ADDR_EDGECAP, 32'h0);
        bus_read(ADDR_EDGECAP, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL w0_keep got %h exp %h", got, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'b0, irq} !== exp) begin errors++; $display("FAIL w0_irq got %b exp %h", irq, exp); end

        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        bus_write(ADDR_EDGECAP, 32'h1);
        bus_read(ADDR_EDGECAP, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL w1c_clear got %h exp %h", got, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'b0, irq} !== exp) begin errors++; $display("FAIL w1c_irq got %b exp %h", irq, exp); end
    endtask

    task automatic test_collision;
        in_port = 8'h05;
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        tick(2);
        bus_write(ADDR_EDGECAP, 32'h4);
        bus_read(ADDR_EDGECAP, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL collision_set got %h exp %h", got, exp); end
        bus_write(ADDR_EDGECAP, 32'h4);
        bus_read(ADDR_EDGECAP, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL collision_clear got %h exp %h", got, exp); end
        tick(3);
        bus_read(ADDR_EDGECAP, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL no_recapture got %h exp %h", got, exp); end
    endtask

    task automatic test_mask;
        bus_write(ADDR_IRQMASK, 32'h0);
        in_port = 8'h25;
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h0);
        tick(4);
        bus_read(ADDR_EDGECAP, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL mask_cap got %h exp %h", got, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'b0, irq} !== exp) begin errors++; $display("FAIL masked_irq got %b exp %h", irq, exp); end

        exp_q.push_back(32'h1);
        exp_q.push_back(32'h20);
        bus_write(ADDR_IRQMASK, 32'hFFFF_FF20);
        exp = exp_q.pop_front(); checks++;
        if ({31'b0, irq} !== exp) begin errors++; $display("FAIL unmask_irq got %b exp %h", irq, exp); end
        bus_read(ADDR_IRQMASK, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL mask_readback got %h exp %h", got, exp); end

        exp_q.push_back(32'h25);
        bus_write(ADDR_DATA, 32'hFFFF_FFFF);
        bus_read(ADDR_DATA, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL data_write_ignored got %h exp %h", got, exp); end

        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        bus_write(ADDR_EDGECAP, 32'hFF);
        bus_read(ADDR_EDGECAP, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL mask_clear got %h exp %h", got, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'b0, irq} !== exp) begin errors++; $display("FAIL mask_clear_irq got %b exp %h", irq, exp); end
    endtask

    task automatic test_any_edge;
        logic [7:0] val;
        bus_write(ADDR_IRQMASK, 32'h80);
        val = 8'h80;
        for (int t = 0; t < 4; t++) begin
            in_port2 = val;
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h80);
            exp_q.push_back(32'h1);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            tick(2);
            bus_read(ADDR_EDGECAP, got, got2);
            exp = exp_q.pop_front(); checks++;
            if (got2 !== exp) begin errors++; $display("FAIL any_early t=%0d got %h exp %h", t, got2, exp); end
            tick(1);
            bus_read(ADDR_EDGECAP, got, got2);
            exp = exp_q.pop_front(); checks++;
            if (got2 !== exp) begin errors++; $display("FAIL any_cap t=%0d got %h exp %h", t, got2, exp); end
            exp = exp_q.pop_front(); checks++;
            if ({31'b0, irq2} !== exp) begin errors++; $display("FAIL any_irq t=%0d got %b exp %h", t, irq2, exp); end
            bus_write(ADDR_EDGECAP, 32'h80);
            bus_read(ADDR_EDGECAP, got, got2);
            exp = exp_q.pop_front(); checks++;
            if (got2 !== exp) begin errors++; $display("FAIL any_clear t=%0d got %h exp %h", t, got2, exp); end
            exp = exp_q.pop_front(); checks++;
            if ({31'b0, irq2} !== exp) begin errors++; $display("FAIL any_clear_irq t=%0d got %b exp %h", t, irq2, exp); end
            val = val ^ 8'h80;
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        bus_read(ADDR_RSVD, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rsvd_read got %h exp %h", got, exp); end
        exp = exp_q.pop_front(); checks++;
        if (got2 !== exp) begin errors++; $display("FAIL rsvd_read_any got %h exp %h", got2, exp); end
    endtask

    task automatic test_mid_reset;
        in_port = 8'h27;
        exp_q.push_back(32'h02);
        tick(4);
        bus_read(ADDR_EDGECAP, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL pre_reset_cap got %h exp %h", got, exp); end

        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        reset = 1'b1;
        bus_read(ADDR_EDGECAP, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL midrst_cap got %h exp %h", got, exp); end
        bus_read(ADDR_DATA, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL midrst_data got %h exp %h", got, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'b0, irq} !== exp) begin errors++; $display("FAIL midrst_irq got %b exp %h", irq, exp); end
        tick(1);
        reset = 1'b0;

        exp_q.push_back(32'h0);
        exp_q.push_back(32'h27);
        tick(5);
        bus_read(ADDR_EDGECAP, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reprime_cap got %h exp %h", got, exp); end
        bus_read(ADDR_DATA, got, got2);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reprime_data got %h exp %h", got, exp); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        in_port2   = '0;
        #1;
        test_reset();
        test_rise_capture();
        test_w1c();
        test_collision();
        test_mask();
        test_any_edge();
        test_mid_reset();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unsaved_gpio_in.md
Name: unsaved_gpio_in

Overview:
Avalon-MM slave input PIO for the Nios GPIO system: the read-side counterpart of the 8-bit output latch on the same bus.
- Samples an external input bus through a synchronizer.
- Captures edges per bit into sticky registers and raises a maskable level interrupt to the Nios.
- Software reads live pin state, masks IRQs per bit, and clears captured edges by writing 1s.

Parameters:
WIDTH, 8, number of input bits (1..32)
SYNC_STAGES, 2, synchronizer flops per bit (2..4)
EDGE_TYPE, 0, edge captured: 0 = rising, 1 = falling, 2 = any

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  2  word address: 0 = data, 2 = irqmask, 3 = edgecapture (1 reserved)
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
in_port  in  WIDTH  external asynchronous inputs
readdata  out  32  read data, zero-extended above WIDTH
irq  out  1  level interrupt to Nios

Behaviour:
- Reset (async assert, sync release) clears:
  - all sync flops
  - the delay register d_prev
  - irqmask and edgecapture
  - the prime counter
  - readdata and irq are therefore 0.
- Write strobe: wr = chipselect & ~write_n. Reads have zero wait states and 0 read latency: readdata is a combinational mux of registered state, and chipselect is not required for the read value.
- Synchronizer: s[0] <= in_port ... s[N-1] <= s[N-2]; d_prev <= s[N-1]. A pin change settling before edge k appears at s[N-1] after edge k+N-1.
- Address 0 read: {0, s[N-1]}. Writes to address 0 are ignored.
- Address 1 read: 0; writes ignored.
- Address 2: irqmask <= writedata[WIDTH-1:0] on wr; reads back irqmask.
- Address 3 read: edgecapture.
  - Write: for each bit, clear if writedata bit = 1, unchanged if 0.
- Edge detect, comb, per bit:
  - rise = s[N-1] & ~d_prev
  - fall = ~s[N-1] & d_prev
  - any = rise | fall, selected by EDGE_TYPE.
- Capture: edgecapture[i] <= 1 on the clock edge where edge[i] = 1 and prime_done. Capture latency is SYNC_STAGES+1 edges from the pin-change sample edge.
- Simultaneous edge detection and write-1-clear on the same bit: the set wins and the bit stays 1.
- Prime counter: counts 0 .. SYNC_STAGES+1 after reset, then saturates. prime_done = (cnt == SYNC_STAGES+1).
  - Edge capture is suppressed until prime_done, so a pin already high at reset release does not produce a false rising edge.
- irq = |(edgecapture & irqmask), combinational from registers. It asserts in the same cycle the captured bit becomes visible and deasserts the cycle after the clearing write.
- Pulses narrower than one clk period may be missed. This is a documented limitation; no requirement is placed on them.
- Reset mid-operation: all state clears immediately, and the prime window restarts.

Decomposition:
- Package unsaved_gpio_pkg holds:
  - address constants ADDR_DATA = 0, ADDR_IRQMASK = 2, ADDR_EDGECAP = 3
  - EDGE_RISE = 0, EDGE_FALL = 1, EDGE_ANY = 2.
- Sub-module unsaved_gpio_sync: WIDTH × SYNC_STAGES synchronizer plus d_prev. It has async active-high reset and outputs s_last and d_prev.
- The top level holds the register file, edge logic, prime counter and read mux.

Test Plan:
1. Reset, defaults, in_port = 0xFF held through reset: readdata at addr 0 = 0x00 during reset, 0xFF after 2 clk. Addr 3 stays 0x00 (prime suppression) and irq = 0.
2. Rising capture, irqmask = 0x01: in_port 0x00 -> 0x01 → addr 3 reads 0x01 exactly 3 edges later, and irq = 1 in the same cycle.
3. Write-1-clear: write 0x01 to addr 3 → next read of addr 3 = 0x00 and irq = 0. Writing 0x00 leaves the captured bits unchanged.
4. Collision: a bit-2 rising edge detected in the same cycle as a write of 0x04 to addr 3 → bit 2 reads 1 afterwards.
5. Mask: irqmask = 0x00 with bit 5 captured → irq = 0. Writing irqmask = 0x20 → irq = 1 next cycle. Addr 2 reads back 0x20.
6. EDGE_TYPE = 2, in_port toggles 0x80 ↔ 0x00 twice: bit 7 captured on each transition. Clear between toggles; each toggle recaptures. Addr 1 reads 0; upper readdata bits are always 0.
